// File: rtl/rotation_matrix_gen.sv
// 3x3 fixed-point rotation matrix generator: single-axis Z/Y/X, or composite ZYX
// built from one shared rounding/saturating multiplier over 14 sequential steps.
module rotation_matrix_gen #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] cos1,
    input  logic signed [WIDTH-1:0] sin1,
    input  logic signed [WIDTH-1:0] cos2,
    input  logic signed [WIDTH-1:0] sin2,
    input  logic signed [WIDTH-1:0] cos3,
    input  logic signed [WIDTH-1:0] sin3,
    output logic signed [WIDTH-1:0] m11,
    output logic signed [WIDTH-1:0] m12,
    output logic signed [WIDTH-1:0] m13,
    output logic signed [WIDTH-1:0] m21,
    output logic signed [WIDTH-1:0] m22,
    output logic signed [WIDTH-1:0] m23,
    output logic signed [WIDTH-1:0] m31,
    output logic signed [WIDTH-1:0] m32,
    output logic signed [WIDTH-1:0] m33,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0]   ZERO_V = {WIDTH{1'b0}};
    localparam logic signed [WIDTH-1:0]   ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH-1:0]   MAX_V  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] MAX_W  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MIN_W  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] RND_W  = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FRAC-1);

    // Clamp a WIDTH+1 bit sum back into WIDTH bits; the top two bits differ only on overflow.
    function automatic logic signed [WIDTH-1:0] sat_narrow(input logic signed [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1]) begin
            return v[WIDTH] ? MIN_V : MAX_V;
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        return sat_narrow({a[WIDTH-1], a} + {b[WIDTH-1], b});
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        return sat_narrow({a[WIDTH-1], a} - {b[WIDTH-1], b});
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] a);
        return sat_narrow({(WIDTH+1){1'b0}} - {a[WIDTH-1], a});
    endfunction

    function automatic logic signed [WIDTH-1:0] mul_round(input logic signed [WIDTH-1:0] a,
                                                          input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] aw;
        logic signed [2*WIDTH-1:0] bw;
        logic signed [2*WIDTH-1:0] r;
        aw = {{WIDTH{a[WIDTH-1]}}, a};
        bw = {{WIDTH{b[WIDTH-1]}}, b};
        r  = ((aw * bw) + RND_W) >>> FRAC;
        if (r > MAX_W) begin
            return MAX_V;
        end else if (r < MIN_W) begin
            return MIN_V;
        end else begin
            return r[WIDTH-1:0];
        end
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [3:0]              step_r;
    logic signed [WIDTH-1:0] c1_r, s1_r, c2_r, s2_r, c3_r, s3_r;
    logic signed [WIDTH-1:0] pa_r, pb_r, tmp_r;
    logic signed [WIDTH-1:0] mul_a_s, mul_b_s, prod_s;
    logic                    accept_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign accept_s  = in_valid && (state_r == IDLE);
    assign prod_s    = mul_round(mul_a_s, mul_b_s);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: accept in IDLE, 14 product steps in CALC, hold DONE until taken.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = (mode == 2'd3) ? CALC : DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (step_r == 4'd13) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Operand select for the shared multiplier; order fixes which step completes each element.
    always_comb begin
        mul_a_s = c1_r;
        mul_b_s = s2_r;
        case (step_r)
            4'd0:    begin mul_a_s = c1_r; mul_b_s = s2_r; end
            4'd1:    begin mul_a_s = s1_r; mul_b_s = s2_r; end
            4'd2:    begin mul_a_s = c1_r; mul_b_s = c2_r; end
            4'd3:    begin mul_a_s = pa_r; mul_b_s = s3_r; end
            4'd4:    begin mul_a_s = s1_r; mul_b_s = c3_r; end
            4'd5:    begin mul_a_s = pa_r; mul_b_s = c3_r; end
            4'd6:    begin mul_a_s = s1_r; mul_b_s = s3_r; end
            4'd7:    begin mul_a_s = s1_r; mul_b_s = c2_r; end
            4'd8:    begin mul_a_s = pb_r; mul_b_s = s3_r; end
            4'd9:    begin mul_a_s = c1_r; mul_b_s = c3_r; end
            4'd10:   begin mul_a_s = pb_r; mul_b_s = c3_r; end
            4'd11:   begin mul_a_s = c1_r; mul_b_s = s3_r; end
            4'd12:   begin mul_a_s = c2_r; mul_b_s = s3_r; end
            4'd13:   begin mul_a_s = c2_r; mul_b_s = c3_r; end
            default: begin mul_a_s = c1_r; mul_b_s = s2_r; end
        endcase
    end

    // Datapath: operand capture, single-axis load on accept, composite accumulation in CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            m11 <= ONE_V;  m12 <= ZERO_V; m13 <= ZERO_V;
            m21 <= ZERO_V; m22 <= ONE_V;  m23 <= ZERO_V;
            m31 <= ZERO_V; m32 <= ZERO_V; m33 <= ONE_V;
            c1_r <= ZERO_V; s1_r <= ZERO_V; c2_r <= ZERO_V;
            s2_r <= ZERO_V; c3_r <= ZERO_V; s3_r <= ZERO_V;
            pa_r <= ZERO_V; pb_r <= ZERO_V; tmp_r <= ZERO_V;
            step_r <= 4'd0;
        end else if (accept_s) begin
            c1_r <= cos1; s1_r <= sin1; c2_r <= cos2;
            s2_r <= sin2; c3_r <= cos3; s3_r <= sin3;
            step_r <= 4'd0;
            case (mode)
                2'd0: begin
                    m11 <= cos1;   m12 <= sat_neg(sin1); m13 <= ZERO_V;
                    m21 <= sin1;   m22 <= cos1;          m23 <= ZERO_V;
                    m31 <= ZERO_V; m32 <= ZERO_V;        m33 <= ONE_V;
                end
                2'd1: begin
                    m11 <= cos2;          m12 <= ZERO_V; m13 <= sin2;
                    m21 <= ZERO_V;        m22 <= ONE_V;  m23 <= ZERO_V;
                    m31 <= sat_neg(sin2); m32 <= ZERO_V; m33 <= cos2;
                end
                2'd2: begin
                    m11 <= ONE_V;  m12 <= ZERO_V; m13 <= ZERO_V;
                    m21 <= ZERO_V; m22 <= cos3;   m23 <= sat_neg(sin3);
                    m31 <= ZERO_V; m32 <= sin3;   m33 <= cos3;
                end
                default: begin
                end
            endcase
        end else if (state_r == CALC) begin
            step_r <= step_r + 4'd1;
            case (step_r)
                4'd0:  begin pa_r <= prod_s; m31 <= sat_neg(s2_r); end
                4'd1:  pb_r  <= prod_s;
                4'd2:  m11   <= prod_s;
                4'd3:  tmp_r <= prod_s;
                4'd4:  m12   <= sat_sub(tmp_r, prod_s);
                4'd5:  tmp_r <= prod_s;
                4'd6:  m13   <= sat_add(tmp_r, prod_s);
                4'd7:  m21   <= prod_s;
                4'd8:  tmp_r <= prod_s;
                4'd9:  m22   <= sat_add(tmp_r, prod_s);
                4'd10: tmp_r <= prod_s;
                4'd11: m23   <= sat_sub(tmp_r, prod_s);
                4'd12: m32   <= prod_s;
                4'd13: m33   <= prod_s;
                default: begin
                end
            endcase
        end else begin
            step_r <= step_r;
        end
    end

endmodule

// File: tb/tb_rotation_matrix_gen.sv
// Directed-vector bench for rotation_matrix_gen: reset, single-axis modes, composite
// results and latency, backpressure, saturation and mid-calculation reset abort.
module tb_rotation_matrix_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] cos1 = 16'h0, sin1 = 16'h0, cos2 = 16'h0, sin2 = 16'h0, cos3 = 16'h0, sin3 = 16'h0;
    logic [15:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
    logic        in_ready, out_valid;
    logic [143:0] mat;

    int checks = 0;
    int errors = 0;

    localparam logic [143:0] IDENT = {16'h1000, 16'h0000, 16'h0000,
                                      16'h0000, 16'h1000, 16'h0000,
                                      16'h0000, 16'h0000, 16'h1000};

    rotation_matrix_gen #(.WIDTH(16), .FRAC(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .cos1(cos1), .sin1(sin1), .cos2(cos2), .sin2(sin2), .cos3(cos3), .sin3(sin3),
        .m11(m11), .m12(m12), .m13(m13), .m21(m21), .m22(m22), .m23(m23),
        .m31(m31), .m32(m32), .m33(m33),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    assign mat = {m11, m12, m13, m21, m22, m23, m31, m32, m33};

    always #5 clk = ~clk;

    task automatic send(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic [15:0] e,
                        input logic [15:0] f);
        @(negedge clk);
        mode = md; cos1 = a; sin1 = b; cos2 = c; sin2 = d; cos3 = e; sin3 = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mat !== IDENT) begin
            errors++; $display("FAIL reset_matrix got %h expected %h", mat, IDENT);
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_handshake got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_axis;
        logic [15:0]  vin [3][6];
        logic [143:0] vexp [3];
        int n;
        vin[0] = '{16'h0DDB, 16'h0800, 16'h0B50, 16'h0400, 16'h0800, 16'h0DDB};
        vin[1] = '{16'h0DDB, 16'h0800, 16'h0B50, 16'h0400, 16'h0800, 16'h0DDB};
        vin[2] = '{16'h0DDB, 16'h0800, 16'h0B50, 16'h0400, 16'h0800, 16'h0DDB};
        vexp[0] = {16'h0DDB, 16'hF800, 16'h0000, 16'h0800, 16'h0DDB, 16'h0000, 16'h0000, 16'h0000, 16'h1000};
        vexp[1] = {16'h0B50, 16'h0000, 16'h0400, 16'h0000, 16'h1000, 16'h0000, 16'hFC00, 16'h0000, 16'h0B50};
        vexp[2] = {16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0800, 16'hF225, 16'h0000, 16'h0DDB, 16'h0800};
        for (int i = 0; i < 3; i++) begin
            send(2'(i), vin[i][0], vin[i][1], vin[i][2], vin[i][3], vin[i][4], vin[i][5]);
            wait_valid(n);
            checks++;
            if (n !== 0) begin
                errors++; $display("FAIL single_latency mode %0d got %0d extra edges expected 0", i, n);
            end
            checks++;
            if (mat !== vexp[i]) begin
                errors++; $display("FAIL single_matrix mode %0d got %h expected %h", i, mat, vexp[i]);
            end
            release_out();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++; $display("FAIL single_release mode %0d got in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_composite;
        logic [15:0]  vin [4][6];
        logic [143:0] vexp [4];
        int n;
        vin[0] = '{16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000};
        vin[1] = '{16'h1000, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'h0000};
        vin[2] = '{16'h0800, 16'h0DDB, 16'h0B50, 16'h0B50, 16'h0DDB, 16'h0800};
        vin[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vexp[0] = IDENT;
        vexp[1] = {16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'hF000, 16'h0000, 16'h0000};
        vexp[2] = {16'h05A8, 16'hF6D4, 16'h0BD4, 16'h09CC, 16'h0BD4, 16'h047C, 16'hF4B0, 16'h05A8, 16'h09CC};
        vexp[3] = {16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        for (int i = 0; i < 4; i++) begin
            send(2'd3, vin[i][0], vin[i][1], vin[i][2], vin[i][3], vin[i][4], vin[i][5]);
            wait_valid(n);
            checks++;
            if (n !== 14) begin
                errors++; $display("FAIL composite_latency vec %0d got %0d edges after accept expected 14", i, n);
            end
            checks++;
            if (mat !== vexp[i]) begin
                errors++; $display("FAIL composite_matrix vec %0d got %h expected %h", i, mat, vexp[i]);
            end
            release_out();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++; $display("FAIL composite_release vec %0d got in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [143:0] exp_m;
        int n;
        exp_m = {16'h0DDB, 16'hF800, 16'h0000, 16'h0800, 16'h0DDB, 16'h0000, 16'h0000, 16'h0000, 16'h1000};
        send(2'd0, 16'h0DDB, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_valid(n);
        @(negedge clk);
        in_valid = 1'b1; mode = 2'd3; cos1 = 16'h1234; sin1 = 16'h0321;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({mat, out_valid, in_ready} !== {exp_m, 1'b1, 1'b0}) begin
                errors++; $display("FAIL backpressure_hold cycle %0d got %h v=%b r=%b expected %h v=1 r=0", k, mat, out_valid, in_ready, exp_m);
            end
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL backpressure_release got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mat, out_valid} !== {exp_m, 1'b0}) begin
            errors++; $display("FAIL backpressure_after got %h v=%b expected %h v=0", mat, out_valid, exp_m);
        end
    endtask

    task automatic test_saturation;
        logic [143:0] exp_m;
        int n;
        exp_m = {16'h1000, 16'h7FFF, 16'h0000, 16'h8000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h1000};
        send(2'd0, 16'h1000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        wait_valid(n);
        checks++;
        if (m12 !== 16'h7FFF) begin
            errors++; $display("FAIL sat_negate m12 got %h expected 7fff", m12);
        end
        checks++;
        if (mat !== exp_m) begin
            errors++; $display("FAIL sat_matrix got %h expected %h", mat, exp_m);
        end
        release_out();
    endtask

    task automatic test_abort;
        logic seen;
        seen = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_precondition in_ready got %b expected 1", in_ready);
        end
        send(2'd3, 16'h0800, 16'h0DDB, 16'h0B50, 16'h0B50, 16'h0DDB, 16'h0800);
        repeat (7) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if ({m11, m13, m31} !== {16'h05A8, 16'h0BD4, 16'hF4B0}) begin
            errors++; $display("FAIL abort_partial got m11=%h m13=%h m31=%h expected 05a8 0bd4 f4b0", m11, m13, m31);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mat, in_ready, out_valid} !== {IDENT, 1'b1, 1'b0}) begin
            errors++; $display("FAIL abort_reset got %h r=%b v=%b expected %h r=1 v=0", mat, in_ready, out_valid, IDENT);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_valid out_valid rose got 1 expected 0");
        end
        checks++;
        if (mat !== IDENT) begin
            errors++; $display("FAIL abort_hold got %h expected %h", mat, IDENT);
        end
    endtask

    initial begin
        test_reset();
        test_single_axis();
        test_composite();
        test_backpressure();
        test_saturation();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
